// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
//   Instruction-fetch controller in front of the instruction ROM/SRAM read path.
//   Owns the PC, issues one word-aligned read at a time, captures the returned
//   instruction and hands it to IF/ID through a valid/stall handshake. A branch
//   that arrives while a read is in flight lets that read finish, throws the
//   data away and then restarts at the branch target, because an external SRAM
//   read cannot be aborted once started.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous reset, active low
//   stall_i          downstream not accepting the presented instruction
//   branch_flag_i    single-cycle redirect request
//   branch_target_i  redirect PC (bits [1:0] forced to zero)
//   rom_rdy_i        read-complete pulse, only honoured while rom_ce_o=1
//   rom_inst_i       read data, valid in the rom_rdy_i cycle
//   rom_addr_o       fetch address {pc[31:2],2'b00}
//   rom_ce_o         fetch request, held high for the whole read
//   inst_o           captured instruction
//   inst_pc_o        PC of inst_o
//   inst_valid_o     inst_o / inst_pc_o valid
//   busy_o           a read is outstanding (FETCH or DISCARD)
// -----------------------------------------------------------------------------
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        rom_rdy_i,
  input  logic [31:0] rom_inst_i,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        busy_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  logic [1:0]  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] inst_pc_reg, inst_pc_next;
  logic        valid_reg, valid_next;
  logic        redirect_pending_reg, redirect_pending_next;
  logic [31:0] redirect_pc_reg, redirect_pc_next;
  logic        ce_reg;

  logic [31:0] target_aligned;
  assign target_aligned = {branch_target_i[31:2], 2'b00};

  always_comb begin
    state_next            = state_reg;
    pc_next               = pc_reg;
    inst_next             = inst_reg;
    inst_pc_next          = inst_pc_reg;
    valid_next            = valid_reg;
    redirect_pending_next = redirect_pending_reg;
    redirect_pc_next      = redirect_pc_reg;

    case (state_reg)
      ST_IDLE: begin
        // One deasserted-request cycle between reads.
        if (branch_flag_i) pc_next = target_aligned;
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        if (rom_rdy_i) begin
          // A branch coincident with the data makes this word the delay slot:
          // it is delivered normally and the PC jumps instead of incrementing.
          inst_next    = rom_inst_i;
          inst_pc_next = pc_reg;
          valid_next   = 1'b1;
          pc_next      = branch_flag_i ? target_aligned : pc_reg + 32'd4;
          state_next   = ST_HOLD;
        end else if (branch_flag_i) begin
          redirect_pending_next = 1'b1;
          redirect_pc_next      = target_aligned;
          state_next            = ST_DISCARD;
        end
      end

      ST_DISCARD: begin
        if (rom_rdy_i) begin
          // Drop the stale word; a branch in this same cycle is the newest.
          pc_next               = branch_flag_i ? target_aligned : redirect_pc_reg;
          redirect_pending_next = 1'b0;
          state_next            = ST_IDLE;
        end else if (branch_flag_i) begin
          redirect_pc_next = target_aligned;
        end
      end

      default: begin // ST_HOLD
        // The PC already points past the held word, so a redirect here only
        // changes where the next read goes; the held word is still delivered.
        if (branch_flag_i) pc_next = target_aligned;
        if (!stall_i) begin
          valid_next = 1'b0;
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg            <= ST_IDLE;
      pc_reg               <= RESET_PC;
      inst_reg             <= 32'd0;
      inst_pc_reg          <= 32'd0;
      valid_reg            <= 1'b0;
      redirect_pending_reg <= 1'b0;
      redirect_pc_reg      <= 32'd0;
      ce_reg               <= 1'b0;
    end else begin
      state_reg            <= state_next;
      pc_reg               <= pc_next;
      inst_reg             <= inst_next;
      inst_pc_reg          <= inst_pc_next;
      valid_reg            <= valid_next;
      redirect_pending_reg <= redirect_pending_next;
      redirect_pc_reg      <= redirect_pc_next;
      // Request flag registered alongside the state so it is glitch-free.
      ce_reg               <= (state_next == ST_FETCH) || (state_next == ST_DISCARD);
    end
  end

  assign rom_addr_o   = {pc_reg[31:2], 2'b00};
  assign rom_ce_o     = ce_reg;
  assign busy_o       = ce_reg;
  assign inst_o       = inst_reg;
  assign inst_pc_o    = inst_pc_reg;
  assign inst_valid_o = valid_reg;

endmodule
